// File: rtl/rx_prbs_checker.sv
// Rx PRBS-7 frame checker. Compares each received frame against the PRBS-7 payload,
// counts per-frame and cumulative bit errors, counts stray bytes and tracks lock.
module rx_prbs_checker #(
  parameter logic [6:0]  SEED       = 7'h7F,
  parameter int unsigned MAX_LEN    = 1024,
  parameter int unsigned ERR_THR    = 8,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input  logic        clk_32M768,
  input  logic        rst_n_32M768,
  input  logic        clr,
  input  logic [7:0]  data_tdata,
  input  logic        data_tvalid,
  input  logic        data_tlast,
  input  logic        data_tuser,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] frame_len,
  output logic [15:0] frame_err,
  output logic [31:0] total_bits,
  output logic [31:0] total_err,
  output logic [15:0] stray_cnt,
  output logic        locked
);

  typedef enum logic [1:0] {StIdle, StFrame, StDrop} state_e;

  // Advance the LFSR eight bits; returns {next_state, expected_byte}, bit0 first on air.
  function automatic logic [14:0] prbs_byte(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] b;
    s = seed;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i] = s[6] ^ s[5];
      s    = {s[5:0], b[i]};
    end
    return {s, b};
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  lfsr_q, lfsr_d, lfsr_first, lfsr_cont;
  logic [7:0]  exp_first, exp_cont;
  logic [3:0]  err_first, err_cont, cmp_err;
  logic [15:0] len_q, len_d, err_q, err_d, out_len, out_err;
  logic [15:0] frame_len_q, frame_err_q, stray_q;
  logic [31:0] total_bits_q, total_err_q;
  logic [32:0] bits_sum, err_sum;
  logic [7:0]  good_run_q, good_run_d, bad_run_q, bad_run_d;
  logic        locked_q, locked_d, done_q, abort_q;
  logic        cmp_en, stray_inc, fin, abt, start, good;

  assign {lfsr_first, exp_first} = prbs_byte(SEED);
  assign {lfsr_cont, exp_cont}   = prbs_byte(lfsr_q);
  assign err_first = 4'($countones(data_tdata ^ exp_first));
  assign err_cont  = 4'($countones(data_tdata ^ exp_cont));

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    len_d     = len_q;
    err_d     = err_q;
    cmp_en    = 1'b0;
    cmp_err   = err_cont;
    stray_inc = 1'b0;
    fin       = 1'b0;
    abt       = 1'b0;
    start     = 1'b0;
    out_len   = len_q;
    out_err   = err_q;
    if (data_tvalid) begin
      unique case (state_q)
        StIdle: begin
          if (data_tuser) start = 1'b1;
          else            stray_inc = 1'b1;
        end
        StFrame: begin
          if (data_tuser) begin
            fin   = 1'b1;
            abt   = 1'b1;
            start = 1'b1;
          end else if (len_q >= 16'(MAX_LEN)) begin
            // Overlong: report what was compared so far, drop the rest of the frame.
            fin     = 1'b1;
            abt     = 1'b1;
            state_d = data_tlast ? StIdle : StDrop;
          end else begin
            cmp_en = 1'b1;
            len_d  = len_q + 16'd1;
            err_d  = err_q + 16'(err_cont);
            lfsr_d = lfsr_cont;
            if (data_tlast) begin
              fin     = 1'b1;
              out_len = len_d;
              out_err = err_d;
              state_d = StIdle;
            end
          end
        end
        StDrop: begin
          if (data_tuser)      start = 1'b1;
          else if (data_tlast) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
      if (start) begin
        cmp_en  = 1'b1;
        cmp_err = err_first;
        len_d   = 16'd1;
        err_d   = 16'(err_first);
        lfsr_d  = lfsr_first;
        state_d = StFrame;
        if (data_tlast) begin
          state_d = StIdle;
          // A restart that also ends reports only the aborted frame.
          if (!fin) begin
            fin     = 1'b1;
            out_len = 16'd1;
            out_err = 16'(err_first);
          end
        end
      end
    end
  end

  assign good = fin && !abt && (out_err <= 16'(ERR_THR));

  always_comb begin
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    locked_d   = locked_q;
    if (fin) begin
      if (good) begin
        bad_run_d = '0;
        if (good_run_q < 8'(LOCK_CNT)) good_run_d = good_run_q + 8'd1;
        if (good_run_d >= 8'(LOCK_CNT)) locked_d = 1'b1;
      end else begin
        good_run_d = '0;
        if (bad_run_q < 8'(UNLOCK_CNT)) bad_run_d = bad_run_q + 8'd1;
        if (bad_run_d >= 8'(UNLOCK_CNT)) locked_d = 1'b0;
      end
    end
  end

  assign bits_sum = {1'b0, total_bits_q} + 33'd8;
  assign err_sum  = {1'b0, total_err_q} + 33'(cmp_err);

  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      state_q      <= StIdle;
      lfsr_q       <= SEED;
      len_q        <= '0;
      err_q        <= '0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      frame_len_q  <= '0;
      frame_err_q  <= '0;
      total_bits_q <= '0;
      total_err_q  <= '0;
      stray_q      <= '0;
      good_run_q   <= '0;
      bad_run_q    <= '0;
      locked_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      len_q   <= len_d;
      err_q   <= err_d;
      done_q  <= fin;
      abort_q <= abt;
      if (fin) begin
        frame_len_q <= out_len;
        frame_err_q <= out_err;
      end
      if (clr) begin
        total_bits_q <= '0;
        total_err_q  <= '0;
        stray_q      <= '0;
        good_run_q   <= '0;
        bad_run_q    <= '0;
        locked_q     <= 1'b0;
      end else begin
        if (cmp_en) begin
          total_bits_q <= bits_sum[32] ? '1 : bits_sum[31:0];
          total_err_q  <= err_sum[32] ? '1 : err_sum[31:0];
        end
        if (stray_inc && stray_q != '1) stray_q <= stray_q + 16'd1;
        good_run_q <= good_run_d;
        bad_run_q  <= bad_run_d;
        locked_q   <= locked_d;
      end
    end
  end

  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign frame_len   = frame_len_q;
  assign frame_err   = frame_err_q;
  assign total_bits  = total_bits_q;
  assign total_err   = total_err_q;
  assign stray_cnt   = stray_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_rx_prbs_checker.sv
// Bench for rx_prbs_checker: directed spec scenarios plus randomized traffic,
// all outputs checked every cycle against a frame-level model.
module tb_rx_prbs_checker;
  localparam int unsigned MaxLen = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic        frame_done, frame_abort, locked;
  logic [15:0] frame_len, frame_err, stray_cnt;
  logic [31:0] total_bits, total_err;

  rx_prbs_checker #(.MAX_LEN(MaxLen)) dut (
    .clk_32M768  (clk),
    .rst_n_32M768(rst_n),
    .clr         (clr),
    .data_tdata  (tdata),
    .data_tvalid (tvalid),
    .data_tlast  (tlast),
    .data_tuser  (tuser),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .frame_len   (frame_len),
    .frame_err   (frame_err),
    .total_bits  (total_bits),
    .total_err   (total_err),
    .stray_cnt   (stray_cnt),
    .locked      (locked)
  );

  always #15 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference PRBS payload, generated bit by bit from x^7+x^6+1.
  logic [7:0] prbs [MaxLen];

  // Model state, frame-level view.
  bit     in_frame, dropping, m_locked, e_done, e_abort;
  int     m_len, m_err, m_stray, good_run, bad_run, e_len, e_err;
  longint m_bits, m_terr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic gen_prbs();
    bit [6:0] s;
    bit       b;
    s = 7'h7F;
    for (int i = 0; i < MaxLen; i++) begin
      for (int j = 0; j < 8; j++) begin
        b = s[6] ^ s[5];
        prbs[i][j] = b;
        s = {s[5:0], b};
      end
    end
  endtask

  task automatic model_reset();
    in_frame = 0; dropping = 0; m_locked = 0; e_done = 0; e_abort = 0;
    m_len = 0; m_err = 0; m_stray = 0; good_run = 0; bad_run = 0; e_len = 0; e_err = 0;
    m_bits = 0; m_terr = 0;
  endtask

  task automatic add_bits(input int e);
    m_bits = (m_bits + 8 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bits + 8;
    m_terr = (m_terr + e > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_terr + e;
  endtask

  task automatic finish(input bit ab, input int l, input int e);
    e_done = 1; e_abort = ab; e_len = l; e_err = e;
    if (!ab && e <= 8) begin
      bad_run = 0; good_run++;
      if (good_run >= 4) m_locked = 1;
    end else begin
      good_run = 0; bad_run++;
      if (bad_run >= 2) m_locked = 0;
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit last, input bit user,
                            input bit c);
    int e;
    e_done = 0; e_abort = 0;
    if (v) begin
      if (user) begin
        if (in_frame) finish(1, m_len, m_err);
        in_frame = 1; dropping = 0; m_len = 1;
        m_err = $countones(d ^ prbs[0]);
        add_bits(m_err);
        if (last) begin
          in_frame = 0;
          if (!e_done) finish(0, 1, m_err);
        end
      end else if (in_frame) begin
        if (m_len == MaxLen) begin
          finish(1, m_len, m_err);
          in_frame = 0; dropping = !last;
        end else begin
          e = $countones(d ^ prbs[m_len]);
          m_len++; m_err += e;
          add_bits(e);
          if (last) begin
            finish(0, m_len, m_err);
            in_frame = 0;
          end
        end
      end else if (dropping) begin
        if (last) dropping = 0;
      end else if (m_stray < 16'hFFFF) begin
        m_stray++;
      end
    end
    if (c) begin
      m_bits = 0; m_terr = 0; m_stray = 0; good_run = 0; bad_run = 0; m_locked = 0;
    end
  endtask

  task automatic check_all();
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_abort", 32'(frame_abort), 32'(e_abort));
    chk("frame_len", 32'(frame_len), 32'(e_len));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    chk("total_bits", total_bits, 32'(m_bits));
    chk("total_err", total_err, 32'(m_terr));
    chk("stray_cnt", 32'(stray_cnt), 32'(m_stray));
    chk("locked", 32'(locked), 32'(m_locked));
  endtask

  // Drive one cycle, advance the model, then check all outputs just after the edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit last, input bit user,
                       input bit c);
    tvalid = v; tdata = d; tlast = last; tuser = user; clr = c;
    model_step(v, d, last, user, c);
    @(posedge clk);
    #1;
    check_all();
    tvalid = 0; tlast = 0; tuser = 0; clr = 0;
  endtask

  task automatic send2(input logic [7:0] b0, input logic [7:0] b1);
    cycle(1, b0, 0, 1, 0);
    cycle(1, b1, 1, 0, 0);
  endtask

  initial begin
    bit         v, user, last, c;
    logic [7:0] d;
    int         r, stray_before;

    gen_prbs();
    model_reset();
    chk("model_prbs0", 32'(prbs[0]), 32'h40);
    chk("model_prbs1", 32'(prbs[1]), 32'h30);

    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
    cycle(0, 8'h00, 0, 0, 0);

    // Clean two-byte frame.
    send2(8'h40, 8'h30);
    chk("f1_done", 32'(frame_done), 1);
    chk("f1_len", 32'(frame_len), 2);
    chk("f1_err", 32'(frame_err), 0);
    chk("f1_bits", total_bits, 16);
    cycle(0, 8'h00, 0, 0, 0);
    chk("f1_done_pulse", 32'(frame_done), 0);

    // One flipped bit, twice.
    send2(8'h41, 8'h30);
    chk("f2_err", 32'(frame_err), 1);
    chk("f2_total_err", total_err, 1);
    send2(8'h41, 8'h30);
    chk("f3_total_err", total_err, 2);

    // Lock acquire and loss.
    cycle(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      send2(8'h40, 8'h30);
      if (i == 2) chk("lock_after3", 32'(locked), 0);
    end
    chk("lock_after4", 32'(locked), 1);
    send2(8'hBF, 8'h31);
    chk("bad1_err", 32'(frame_err), 9);
    chk("lock_bad1", 32'(locked), 1);
    send2(8'hBF, 8'h31);
    chk("lock_bad2", 32'(locked), 0);

    // Single-byte frame, then stray bytes.
    cycle(1, 8'h40, 1, 1, 0);
    chk("single_len", 32'(frame_len), 1);
    chk("single_err", 32'(frame_err), 0);
    chk("single_abort", 32'(frame_abort), 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 0, 0, 0);
    chk("stray3", 32'(stray_cnt), 3);

    // Restart mid-frame after five bytes.
    for (int i = 0; i < 5; i++) cycle(1, prbs[i], 0, (i == 0), 0);
    cycle(1, 8'h40, 0, 1, 0);
    chk("restart_done", 32'(frame_done), 1);
    chk("restart_abort", 32'(frame_abort), 1);
    chk("restart_len", 32'(frame_len), 5);
    cycle(1, 8'h30, 1, 0, 0);
    chk("restart_new_len", 32'(frame_len), 2);
    chk("restart_new_err", 32'(frame_err), 0);

    // Overlong frame.
    stray_before = m_stray;
    for (int i = 0; i < MaxLen; i++) cycle(1, prbs[i], 0, (i == 0), 0);
    cycle(1, 8'h5A, 0, 0, 0);
    chk("ovf_abort", 32'(frame_abort), 1);
    chk("ovf_len", 32'(frame_len), MaxLen);
    chk("ovf_err", 32'(frame_err), 0);
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 1, 0, 0);
    chk("ovf_no_stray", 32'(stray_cnt), 32'(stray_before));
    chk("ovf_bits", total_bits, 32'(m_bits));

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 3; i++) cycle(1, prbs[i], 0, (i == 0), 0);
    #5 rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1;
    cycle(0, 8'h00, 0, 0, 0);
    chk("rst_no_done", 32'(frame_done), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      v    = ($urandom_range(9) < 7);
      user = ($urandom_range(14) == 0);
      last = ($urandom_range(9) == 0);
      c    = ($urandom_range(299) == 0);
      if (in_frame && user) last = 0;
      if (user || !in_frame) d = prbs[0];
      else if (m_len < MaxLen) d = prbs[m_len];
      else d = 8'($urandom);
      r = $urandom_range(9);
      if (r < 2) d = d ^ 8'(1 << $urandom_range(7));
      else if (r == 2) d = 8'($urandom);
      cycle(v, d, last, user, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
